// File: rtl/sc_microsequencer_if.sv
// ----------------------------------------------------------------------------
// sc_microsequencer_if
// Bundles the signals between the sc_microsequencer controller and the
// uDataPath register-file/ALU datapath.
//
//   Datapath -> controller : IR fields (OP, RD, OP2, OP3, RS1, BIT13, RS2),
//                            PSR flags (V, C, N, Z) and memory read-ready.
//   Controller -> datapath : register write select, bus A/B source selects,
//                            ALU operation, instruction fetch strobe and the
//                            sticky illegal-instruction flag.
//
// Modports:
//   master : the controller side (drives selects, samples IR/flags)
//   slave  : the datapath side (drives IR/flags, samples selects)
// ----------------------------------------------------------------------------
interface sc_microsequencer_if #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION     = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4
);
    logic [1:0] SC_MICROSEQUENCER_RegIR_OP;
    logic [4:0] SC_MICROSEQUENCER_RegIR_RD;
    logic [2:0] SC_MICROSEQUENCER_RegIR_OP2;
    logic [5:0] SC_MICROSEQUENCER_RegIR_OP3;
    logic [4:0] SC_MICROSEQUENCER_RegIR_RS1;
    logic       SC_MICROSEQUENCER_RegIR_BIT13;
    logic [4:0] SC_MICROSEQUENCER_RegIR_RS2;
    logic       SC_MICROSEQUENCER_Overflow_InHigh;
    logic       SC_MICROSEQUENCER_Carry_InHigh;
    logic       SC_MICROSEQUENCER_Negative_InHigh;
    logic       SC_MICROSEQUENCER_Zero_InHigh;
    logic       SC_MICROSEQUENCER_MemReady_InHigh;

    logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_MICROSEQUENCER_DecoderSelectionWrite_Out;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSA_Out;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSB_Out;
    logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_MICROSEQUENCER_ALUSelection_Out;
    logic                                   SC_MICROSEQUENCER_MemRead_OutHigh;
    logic                                   SC_MICROSEQUENCER_Illegal_OutHigh;

    modport master (
        input  SC_MICROSEQUENCER_RegIR_OP,
        input  SC_MICROSEQUENCER_RegIR_RD,
        input  SC_MICROSEQUENCER_RegIR_OP2,
        input  SC_MICROSEQUENCER_RegIR_OP3,
        input  SC_MICROSEQUENCER_RegIR_RS1,
        input  SC_MICROSEQUENCER_RegIR_BIT13,
        input  SC_MICROSEQUENCER_RegIR_RS2,
        input  SC_MICROSEQUENCER_Overflow_InHigh,
        input  SC_MICROSEQUENCER_Carry_InHigh,
        input  SC_MICROSEQUENCER_Negative_InHigh,
        input  SC_MICROSEQUENCER_Zero_InHigh,
        input  SC_MICROSEQUENCER_MemReady_InHigh,
        output SC_MICROSEQUENCER_DecoderSelectionWrite_Out,
        output SC_MICROSEQUENCER_MUXSelectionBUSA_Out,
        output SC_MICROSEQUENCER_MUXSelectionBUSB_Out,
        output SC_MICROSEQUENCER_ALUSelection_Out,
        output SC_MICROSEQUENCER_MemRead_OutHigh,
        output SC_MICROSEQUENCER_Illegal_OutHigh
    );

    modport slave (
        output SC_MICROSEQUENCER_RegIR_OP,
        output SC_MICROSEQUENCER_RegIR_RD,
        output SC_MICROSEQUENCER_RegIR_OP2,
        output SC_MICROSEQUENCER_RegIR_OP3,
        output SC_MICROSEQUENCER_RegIR_RS1,
        output SC_MICROSEQUENCER_RegIR_BIT13,
        output SC_MICROSEQUENCER_RegIR_RS2,
        output SC_MICROSEQUENCER_Overflow_InHigh,
        output SC_MICROSEQUENCER_Carry_InHigh,
        output SC_MICROSEQUENCER_Negative_InHigh,
        output SC_MICROSEQUENCER_Zero_InHigh,
        output SC_MICROSEQUENCER_MemReady_InHigh,
        input  SC_MICROSEQUENCER_DecoderSelectionWrite_Out,
        input  SC_MICROSEQUENCER_MUXSelectionBUSA_Out,
        input  SC_MICROSEQUENCER_MUXSelectionBUSB_Out,
        input  SC_MICROSEQUENCER_ALUSelection_Out,
        input  SC_MICROSEQUENCER_MemRead_OutHigh,
        input  SC_MICROSEQUENCER_Illegal_OutHigh
    );
endinterface

// File: rtl/sc_microsequencer.sv
// ----------------------------------------------------------------------------
// sc_microsequencer
// Control unit sequencing the uDataPath datapath through fetch, decode and
// execute of the ARC (SPARC-subset) instruction set.
//
// Ports:
//   SC_MICROSEQUENCER_CLOCK_50     : system clock, rising edge
//   SC_MICROSEQUENCER_Reset_InLow  : synchronous active-low reset (-> IDLE)
//   SC_MICROSEQUENCER_Step_InHigh  : single-step release (optional feature)
//   seqBus (sc_microsequencer_if.master):
//     in  : IR fields OP/RD/OP2/OP3/RS1/BIT13/RS2, PSR V/C/N/Z, MemReady
//     out : write select, bus A/B selects, ALU op, MemRead, Illegal
//
// Optional feature macro: SC_MICROSEQUENCER_SINGLESTEP_EN
//   When defined, each completed instruction parks in HALT until Step=1.
//
// All outputs are Moore decodes of the state register plus IR fields; the
// only input-dependent output is the FETCH write select, which loads IR
// only in the cycle the memory reports ready.
// ----------------------------------------------------------------------------
module sc_microsequencer #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION     = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4
) (
    input  logic                      SC_MICROSEQUENCER_CLOCK_50,
    input  logic                      SC_MICROSEQUENCER_Reset_InLow,
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    input  logic                      SC_MICROSEQUENCER_Step_InHigh,
`endif
    sc_microsequencer_if.master       seqBus
);

    // Register file addresses seen by the write decoder and bus muxes
    localparam logic [5:0] ADDR_R15   = 6'd15;
    localparam logic [5:0] ADDR_PC    = 6'd32;
    localparam logic [5:0] ADDR_TEMP0 = 6'd33;
    localparam logic [5:0] ADDR_TEMP1 = 6'd34;
    localparam logic [5:0] ADDR_IR    = 6'd37;
    localparam logic [5:0] ADDR_NONE  = 6'd63;

    // ALU operation codes
    localparam logic [3:0] ALU_ANDCC    = 4'd0;
    localparam logic [3:0] ALU_ORCC     = 4'd1;
    localparam logic [3:0] ALU_ORNCC    = 4'd2;
    localparam logic [3:0] ALU_ADDCC    = 4'd3;
    localparam logic [3:0] ALU_SRL      = 4'd4;
    localparam logic [3:0] ALU_ADD      = 4'd8;
    localparam logic [3:0] ALU_LSHIFT2  = 4'd9;
    localparam logic [3:0] ALU_LSHIFT10 = 4'd10;
    localparam logic [3:0] ALU_SEXT13   = 4'd12;
    localparam logic [3:0] ALU_INCPC    = 4'd14;
    localparam logic [3:0] ALU_RSHIFT5  = 4'd15;

    typedef enum logic [4:0] {
        IDLE   = 5'd0,
        FETCH  = 5'd1,
        DECODE = 5'd2,
        IMM    = 5'd3,
        ALU    = 5'd4,
        SETHI  = 5'd5,
        BEVAL  = 5'd6,
        BR1    = 5'd7,
        BR2    = 5'd8,
        BR3    = 5'd9,
        BR4    = 5'd10,
        BR5    = 5'd11,
        CALL1  = 5'd12,
        CALL2  = 5'd13,
        CALL3  = 5'd14,
        INC    = 5'd15,
        TRAP   = 5'd16,
        HALT   = 5'd17
    } seqState_t;

    seqState_t stateReg;
    seqState_t stateNext;

    // Where a finished instruction goes: straight to FETCH, or parked in HALT
    seqState_t afterInstr;
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    assign afterInstr = HALT;
`else
    assign afterInstr = FETCH;
`endif

    logic [5:0] decSel;
    logic [5:0] busASel;
    logic [5:0] busBSel;
    logic [3:0] aluSel;
    logic       memRead;
    logic       illegal;

    // Maps an arithmetic OP3 to {supported, ALU op}
    function automatic logic [4:0] decodeAluOp(input logic [5:0] op3);
        logic [4:0] result;
        case (op3)
            6'b010000: result = {1'b1, ALU_ADDCC};
            6'b010001: result = {1'b1, ALU_ANDCC};
            6'b010010: result = {1'b1, ALU_ORCC};
            6'b010110: result = {1'b1, ALU_ORNCC};
            6'b100110: result = {1'b1, ALU_SRL};
            default:   result = {1'b0, ALU_ANDCC};
        endcase
        return result;
    endfunction

    // Evaluates a branch condition to {supported, taken}
    function automatic logic [1:0] evalBranch(input logic [3:0] cond,
                                              input logic z, input logic c,
                                              input logic n, input logic v);
        logic [1:0] result;
        case (cond)
            4'b0001: result = {1'b1, z};
            4'b0101: result = {1'b1, c};
            4'b0110: result = {1'b1, n};
            4'b0111: result = {1'b1, v};
            4'b1000: result = {1'b1, 1'b1};
            default: result = {1'b0, 1'b0};
        endcase
        return result;
    endfunction

    logic [4:0] aluDecode;
    logic [1:0] branchEval;
    assign aluDecode  = decodeAluOp(seqBus.SC_MICROSEQUENCER_RegIR_OP3);
    assign branchEval = evalBranch(seqBus.SC_MICROSEQUENCER_RegIR_RD[3:0],
                                   seqBus.SC_MICROSEQUENCER_Zero_InHigh,
                                   seqBus.SC_MICROSEQUENCER_Carry_InHigh,
                                   seqBus.SC_MICROSEQUENCER_Negative_InHigh,
                                   seqBus.SC_MICROSEQUENCER_Overflow_InHigh);

    // State register with synchronous active-low reset
    always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50) begin
        if (!SC_MICROSEQUENCER_Reset_InLow) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: stateNext = FETCH;
            FETCH: begin
                if (seqBus.SC_MICROSEQUENCER_MemReady_InHigh) begin
                    stateNext = DECODE;
                end else begin
                    stateNext = FETCH;
                end
            end
            DECODE: begin
                if (seqBus.SC_MICROSEQUENCER_RegIR_OP == 2'd2 && aluDecode[4]) begin
                    if (seqBus.SC_MICROSEQUENCER_RegIR_BIT13) begin
                        stateNext = IMM;
                    end else begin
                        stateNext = ALU;
                    end
                end else if (seqBus.SC_MICROSEQUENCER_RegIR_OP == 2'd0 &&
                             seqBus.SC_MICROSEQUENCER_RegIR_OP2 == 3'b100) begin
                    stateNext = SETHI;
                end else if (seqBus.SC_MICROSEQUENCER_RegIR_OP == 2'd0 &&
                             seqBus.SC_MICROSEQUENCER_RegIR_OP2 == 3'b010) begin
                    stateNext = BEVAL;
                end else if (seqBus.SC_MICROSEQUENCER_RegIR_OP == 2'd1) begin
                    stateNext = CALL1;
                end else begin
                    stateNext = TRAP;
                end
            end
            IMM:   stateNext = ALU;
            ALU:   stateNext = INC;
            SETHI: stateNext = INC;
            BEVAL: begin
                if (!branchEval[1]) begin
                    stateNext = TRAP;
                end else if (branchEval[0]) begin
                    stateNext = BR1;
                end else begin
                    stateNext = INC;
                end
            end
            BR1:   stateNext = BR2;
            BR2:   stateNext = BR3;
            BR3:   stateNext = BR4;
            BR4:   stateNext = BR5;
            BR5:   stateNext = afterInstr;
            CALL1: stateNext = CALL2;
            CALL2: stateNext = CALL3;
            CALL3: stateNext = afterInstr;
            INC:   stateNext = afterInstr;
            TRAP:  stateNext = TRAP;
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
            HALT: begin
                if (SC_MICROSEQUENCER_Step_InHigh) begin
                    stateNext = FETCH;
                end else begin
                    stateNext = HALT;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    // Output decode: IDLE/HALT values are the defaults
    always_comb begin
        decSel  = ADDR_NONE;
        busASel = 6'd0;
        busBSel = 6'd0;
        aluSel  = ALU_ANDCC;
        memRead = 1'b0;
        illegal = 1'b0;
        case (stateReg)
            FETCH: begin
                memRead = 1'b1;
                busASel = ADDR_PC;
                if (seqBus.SC_MICROSEQUENCER_MemReady_InHigh) begin
                    decSel = ADDR_IR;
                end else begin
                    decSel = ADDR_NONE;
                end
            end
            IMM: begin
                decSel  = ADDR_TEMP1;
                busASel = ADDR_IR;
                aluSel  = ALU_SEXT13;
            end
            ALU: begin
                decSel  = {1'b0, seqBus.SC_MICROSEQUENCER_RegIR_RD};
                busASel = {1'b0, seqBus.SC_MICROSEQUENCER_RegIR_RS1};
                aluSel  = aluDecode[3:0];
                // The immediate was sign-extended into TEMP1 by IMM
                if (seqBus.SC_MICROSEQUENCER_RegIR_BIT13) begin
                    busBSel = ADDR_TEMP1;
                end else begin
                    busBSel = {1'b0, seqBus.SC_MICROSEQUENCER_RegIR_RS2};
                end
            end
            SETHI: begin
                decSel  = {1'b0, seqBus.SC_MICROSEQUENCER_RegIR_RD};
                busASel = ADDR_IR;
                aluSel  = ALU_LSHIFT10;
            end
            // disp22 is isolated by shifting left 10 then arithmetic right 10,
            // then scaled by 4 before being added to PC
            BR1: begin
                decSel  = ADDR_TEMP0;
                busASel = ADDR_IR;
                aluSel  = ALU_LSHIFT10;
            end
            BR2, BR3: begin
                decSel  = ADDR_TEMP0;
                busASel = ADDR_TEMP0;
                aluSel  = ALU_RSHIFT5;
            end
            BR4: begin
                decSel  = ADDR_TEMP0;
                busASel = ADDR_TEMP0;
                aluSel  = ALU_LSHIFT2;
            end
            BR5, CALL3: begin
                decSel  = ADDR_PC;
                busASel = ADDR_PC;
                busBSel = ADDR_TEMP0;
                aluSel  = ALU_ADD;
            end
            // Return address is PC + r0, i.e. a plain copy of PC
            CALL1: begin
                decSel  = ADDR_R15;
                busASel = ADDR_PC;
                busBSel = 6'd0;
                aluSel  = ALU_ADD;
            end
            CALL2: begin
                decSel  = ADDR_TEMP0;
                busASel = ADDR_IR;
                aluSel  = ALU_LSHIFT2;
            end
            INC: begin
                decSel  = ADDR_PC;
                busASel = ADDR_PC;
                aluSel  = ALU_INCPC;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                decSel = ADDR_NONE;
            end
        endcase
    end

    assign seqBus.SC_MICROSEQUENCER_DecoderSelectionWrite_Out = decSel;
    assign seqBus.SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = busASel;
    assign seqBus.SC_MICROSEQUENCER_MUXSelectionBUSB_Out      = busBSel;
    assign seqBus.SC_MICROSEQUENCER_ALUSelection_Out          = aluSel;
    assign seqBus.SC_MICROSEQUENCER_MemRead_OutHigh           = memRead;
    assign seqBus.SC_MICROSEQUENCER_Illegal_OutHigh           = illegal;

endmodule

// File: tb/tb_sc_microsequencer.sv
// ----------------------------------------------------------------------------
// tb_sc_microsequencer
// Directed bench for sc_microsequencer: drives IR fields / flags / MemReady
// through the interface and checks the control outputs cycle by cycle.
// Inputs change #1 after a rising edge; outputs are checked #2 after it.
// An expected value of -1 marks a field the step does not constrain.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_microsequencer;

    logic clk;
    logic rstN;
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
    logic step;
`endif

    int nAsserts;
    int nFail;

    sc_microsequencer_if seqIf ();

    sc_microsequencer dut (
        .SC_MICROSEQUENCER_CLOCK_50    (clk),
        .SC_MICROSEQUENCER_Reset_InLow (rstN),
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
        .SC_MICROSEQUENCER_Step_InHigh (step),
`endif
        .seqBus                        (seqIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; leaves time just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIR(input logic [31:0] ir);
        seqIf.SC_MICROSEQUENCER_RegIR_OP    = ir[31:30];
        seqIf.SC_MICROSEQUENCER_RegIR_RD    = ir[29:25];
        seqIf.SC_MICROSEQUENCER_RegIR_OP2   = ir[24:22];
        seqIf.SC_MICROSEQUENCER_RegIR_OP3   = ir[24:19];
        seqIf.SC_MICROSEQUENCER_RegIR_RS1   = ir[18:14];
        seqIf.SC_MICROSEQUENCER_RegIR_BIT13 = ir[13];
        seqIf.SC_MICROSEQUENCER_RegIR_RS2   = ir[4:0];
    endtask

    task automatic setFlags(input logic v, input logic c, input logic n, input logic z);
        seqIf.SC_MICROSEQUENCER_Overflow_InHigh = v;
        seqIf.SC_MICROSEQUENCER_Carry_InHigh    = c;
        seqIf.SC_MICROSEQUENCER_Negative_InHigh = n;
        seqIf.SC_MICROSEQUENCER_Zero_InHigh     = z;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        if (exp >= 0) begin
            nAsserts++;
            assert (obs === exp) else begin
                nFail++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
        end
    endtask

    // Checks all outputs for the current cycle (-1 = unconstrained)
    task automatic chkOut(input string tag, input int dec, input int busA,
                          input int busB, input int alu, input int mr, input int ill);
        #1;
        chk({tag, ".dec"},  int'(seqIf.SC_MICROSEQUENCER_DecoderSelectionWrite_Out), dec);
        chk({tag, ".busA"}, int'(seqIf.SC_MICROSEQUENCER_MUXSelectionBUSA_Out), busA);
        chk({tag, ".busB"}, int'(seqIf.SC_MICROSEQUENCER_MUXSelectionBUSB_Out), busB);
        chk({tag, ".alu"},  int'(seqIf.SC_MICROSEQUENCER_ALUSelection_Out), alu);
        chk({tag, ".mr"},   int'(seqIf.SC_MICROSEQUENCER_MemRead_OutHigh), mr);
        chk({tag, ".ill"},  int'(seqIf.SC_MICROSEQUENCER_Illegal_OutHigh), ill);
    endtask

    task automatic chkIdle(input string tag);
        chkOut(tag, 63, 0, 0, 0, 0, 0);
    endtask

    // FETCH with MemReady=1, then DECODE
    task automatic fetchDecode(input string tag);
        chkOut({tag, ".fetch"}, 37, 32, -1, -1, 1, 0);
        tick();
        chkOut({tag, ".decode"}, 63, -1, -1, -1, 0, 0);
        tick();
    endtask

    initial begin
        nAsserts = 0;
        nFail    = 0;
        rstN     = 1'b0;
`ifdef SC_MICROSEQUENCER_SINGLESTEP_EN
        step     = 1'b1;
`endif
        setIR(32'h0000_0000);
        setFlags(1'b0, 1'b0, 1'b0, 1'b0);
        seqIf.SC_MICROSEQUENCER_MemReady_InHigh = 1'b1;

        // Reset: three edges with reset low -> IDLE
        for (int i = 0; i < 3; i++) begin
            tick();
            chkIdle("reset");
        end
        rstN = 1'b1;
        chkIdle("idleAfterRelease");
        tick();

        // addcc r3,r1,r2: 4 cycles
        setIR(32'h8680_4002);
        fetchDecode("addcc");
        chkOut("addcc.alu", 3, 1, 2, 3, 0, 0);
        tick();
        chkOut("addcc.inc", 32, 32, -1, 14, 0, 0);
        tick();

        // orcc r4,r1,-1 with two wait cycles
        setIR(32'h8890_7FFF);
        seqIf.SC_MICROSEQUENCER_MemReady_InHigh = 1'b0;
        chkOut("orcc.wait0", 63, 32, -1, -1, 1, 0);
        tick();
        chkOut("orcc.wait1", 63, 32, -1, -1, 1, 0);
        tick();
        seqIf.SC_MICROSEQUENCER_MemReady_InHigh = 1'b1;
        fetchDecode("orcc");
        chkOut("orcc.imm", 34, 37, -1, 12, 0, 0);
        tick();
        chkOut("orcc.alu", 4, 1, 34, 1, 0, 0);
        tick();
        chkOut("orcc.inc", 32, 32, -1, 14, 0, 0);
        tick();

        // sethi r5
        setIR(32'h0B01_2345);
        fetchDecode("sethi");
        chkOut("sethi.exec", 5, 37, -1, 10, 0, 0);
        tick();
        chkOut("sethi.inc", 32, 32, -1, 14, 0, 0);
        tick();

        // be taken (Z=1): BR1..BR5 then FETCH with no INC
        setIR(32'h0280_0005);
        setFlags(1'b0, 1'b0, 1'b0, 1'b1);
        fetchDecode("beT");
        chkOut("beT.beval", 63, -1, -1, -1, 0, 0);
        tick();
        chkOut("beT.br1", 33, 37, -1, 10, 0, 0);
        tick();
        chkOut("beT.br2", 33, 33, -1, 15, 0, 0);
        tick();
        chkOut("beT.br3", 33, 33, -1, 15, 0, 0);
        tick();
        chkOut("beT.br4", 33, 33, -1, 9, 0, 0);
        tick();
        chkOut("beT.br5", 32, 32, 33, 8, 0, 0);
        tick();

        // be not taken (Z=0): BEVAL then INC
        setFlags(1'b0, 1'b0, 1'b0, 1'b0);
        fetchDecode("beN");
        chkOut("beN.beval", 63, -1, -1, -1, 0, 0);
        tick();
        chkOut("beN.inc", 32, 32, -1, 14, 0, 0);
        tick();

        // call
        setIR(32'h4000_0010);
        fetchDecode("call");
        chkOut("call.c1", 15, 32, 0, 8, 0, 0);
        tick();
        chkOut("call.c2", 33, 37, -1, 9, 0, 0);
        tick();
        chkOut("call.c3", 32, 32, 33, 8, 0, 0);
        tick();
        chkOut("call.next", 37, 32, -1, -1, 1, 0);

        // Reset asserted mid-BR3
        setIR(32'h0280_0005);
        setFlags(1'b0, 1'b0, 1'b0, 1'b1);
        fetchDecode("beR");
        tick();
        tick();
        tick();
        chkOut("beR.br3", 33, 33, -1, 15, 0, 0);
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkIdle("midBranchReset");
        end
        rstN = 1'b1;
        chkIdle("midBranchRelease");
        tick();
        chkOut("afterRelease.fetch", 37, 32, -1, -1, 1, 0);

        // ld (OP=3) -> TRAP, held
        setIR(32'hC000_0000);
        tick();
        chkOut("ld.decode", 63, -1, -1, -1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chkOut("ld.trap", 63, -1, -1, -1, 0, 1);
        end
        rstN = 1'b0;
        tick();
        chkIdle("trapReset");
        rstN = 1'b1;
        tick();

        // Branch cond 0000 -> TRAP via BEVAL
        setIR(32'h0080_0000);
        fetchDecode("bn");
        chkOut("bn.beval", 63, -1, -1, -1, 0, 0);
        tick();
        chkOut("bn.trap", 63, -1, -1, -1, 0, 1);
        tick();
        chkOut("bn.trapHeld", 63, -1, -1, -1, 0, 1);
        rstN = 1'b0;
        tick();
        chkIdle("bnReset");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
